// File: rtl/dreg_alu_pkg.sv
// Shared op/size codes, CCR bit positions and FSM encoding for the data-register ALU sequencer.
package dreg_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_EOR  = 3'b100;
  localparam logic [2:0] OP_MOVE = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;

  localparam int unsigned CCR_W = 5;
  localparam int unsigned CCR_X = 4;
  localparam int unsigned CCR_N = 3;
  localparam int unsigned CCR_Z = 2;
  localparam int unsigned CCR_V = 1;
  localparam int unsigned CCR_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_SLICE = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Operand width in bits for a size code; illegal codes map to long and are rejected elsewhere.
  function automatic int unsigned op_width(input logic [1:0] size);
    int unsigned w;
    case (size)
      SZ_BYTE: w = 8;
      SZ_WORD: w = 16;
      default: w = 32;
    endcase
    return w;
  endfunction

  // Only ops up to MOVE and sizes up to long are executable.
  function automatic logic cmd_is_legal(input logic [2:0] op, input logic [1:0] size);
    return (op <= OP_MOVE) && (size <= SZ_LONG);
  endfunction

endpackage

// File: rtl/dreg_alu_sequencer_alu_slice.sv
// One combinational ALU slice; only bits [msb:0] are significant, carry/overflow taken at msb.
module alu_slice
  import dreg_alu_pkg::*;
#(
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned MSB_W   = $clog2(SLICE_W)
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [2:0]         op,
  input  logic               cin,
  input  logic [MSB_W-1:0]   msb,
  output logic [SLICE_W-1:0] result,
  output logic               cout,
  output logic               ovf,
  output logic               zero,
  output logic               msb_out
);

  localparam int unsigned EXT_W = SLICE_W + 1;
  localparam logic [SLICE_W-1:0] ONES = '1;

  logic [SLICE_W-1:0] mask;
  logic [SLICE_W-1:0] onehot;
  logic [SLICE_W-1:0] am;
  logic [SLICE_W-1:0] bm;
  logic [EXT_W-1:0]   ext;
  logic [EXT_W-1:0]   cin_ext;
  logic               a_msb;
  logic               b_msb;
  logic               is_add;
  logic               is_sub;

  // a OP b on the masked operands, with carry/borrow and overflow read at the msb position.
  always_comb begin
    mask    = ONES >> (32'(SLICE_W - 1) - 32'(msb));
    onehot  = SLICE_W'(1) << msb;
    am      = a & mask;
    bm      = b & mask;
    cin_ext = EXT_W'(cin);
    ext     = '0;
    is_add  = 1'b0;
    is_sub  = 1'b0;
    case (op)
      OP_ADD: begin
        ext    = {1'b0, am} + {1'b0, bm} + cin_ext;
        is_add = 1'b1;
      end
      OP_SUB: begin
        ext    = {1'b0, am} - {1'b0, bm} - cin_ext;
        is_sub = 1'b1;
      end
      OP_AND:  ext = {1'b0, am & bm};
      OP_OR:   ext = {1'b0, am | bm};
      OP_EOR:  ext = {1'b0, am ^ bm};
      OP_MOVE: ext = {1'b0, bm};
      default: ext = '0;
    endcase
    result  = ext[SLICE_W-1:0] & mask;
    msb_out = |(result & onehot);
    zero    = (result == '0);
    a_msb   = |(am & onehot);
    b_msb   = |(bm & onehot);
    cout    = (is_add | is_sub) & |(ext[SLICE_W:1] & onehot);
    ovf     = (is_add & (a_msb == b_msb) & (msb_out != a_msb)) |
              (is_sub & (a_msb != b_msb) & (msb_out != a_msb));
  end

endmodule

// File: rtl/dreg_alu_sequencer.sv
// Multi-cycle dst <= dst OP src sequencer over the data register file, slice by slice, with 68k CCR.
module dreg_alu_sequencer
  import dreg_alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned SEL_W   = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_size,
  input  logic [SEL_W-1:0]  cmd_src,
  input  logic [SEL_W-1:0]  cmd_dst,
  output logic [SEL_W-1:0]  rf_sel_a,
  output logic [SEL_W-1:0]  rf_sel_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic              rf_we,
  output logic [SEL_W-1:0]  rf_wsel,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              illegal,
  output logic [CCR_W-1:0]  ccr
);

  localparam int unsigned MAX_K = DATA_W / SLICE_W;
  localparam int unsigned CNT_W = $clog2(MAX_K) + 1;
  localparam int unsigned MSB_W = $clog2(SLICE_W);

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          size_q, size_d;
  logic [SEL_W-1:0]    dst_q, dst_d;
  logic                ill_q, ill_d;
  logic [DATA_W-1:0]   src_val_q, src_val_d;
  logic [DATA_W-1:0]   dst_val_q, dst_val_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                z_q, z_d;

  logic                cmd_ready_d;
  logic [SEL_W-1:0]    rf_sel_a_d, rf_sel_b_d, rf_wsel_d;
  logic                rf_we_d, done_d, illegal_d;
  logic [DATA_W-1:0]   rf_wdata_d;
  logic [CCR_W-1:0]    ccr_d;

  int unsigned         op_w;
  logic [CNT_W-1:0]    k_last;
  logic [MSB_W-1:0]    msb_idx;
  logic [DATA_W-1:0]   wmask;
  logic [SLICE_W-1:0]  s_a, s_b, s_result;
  logic                s_cout, s_ovf, s_zero, s_msb;
  logic                arith;

  // Size-dependent slice count, significant msb within a slice, merge mask and current slice operands.
  always_comb begin
    op_w    = op_width(size_q);
    k_last  = CNT_W'((op_w + SLICE_W - 1) / SLICE_W - 1);
    msb_idx = (op_w < SLICE_W) ? MSB_W'(op_w - 1) : MSB_W'(SLICE_W - 1);
    wmask   = (DATA_W'(1) << op_w) - DATA_W'(1);
    s_a     = SLICE_W'(dst_val_q >> (32'(cnt_q) * SLICE_W));
    s_b     = SLICE_W'(src_val_q >> (32'(cnt_q) * SLICE_W));
    arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
  end

  alu_slice #(
    .SLICE_W (SLICE_W),
    .MSB_W   (MSB_W)
  ) u_alu_slice (
    .a       (s_a),
    .b       (s_b),
    .op      (op_q),
    .cin     (carry_q),
    .msb     (msb_idx),
    .result  (s_result),
    .cout    (s_cout),
    .ovf     (s_ovf),
    .zero    (s_zero),
    .msb_out (s_msb)
  );

  // Next state and next values of every registered output; pulses default low.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    size_d      = size_q;
    dst_d       = dst_q;
    ill_d       = ill_q;
    src_val_d   = src_val_q;
    dst_val_d   = dst_val_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    z_d         = z_q;
    rf_sel_a_d  = rf_sel_a;
    rf_sel_b_d  = rf_sel_b;
    rf_wsel_d   = rf_wsel;
    rf_wdata_d  = rf_wdata;
    ccr_d       = ccr;
    rf_we_d     = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          size_d     = cmd_size;
          dst_d      = cmd_dst;
          rf_sel_a_d = cmd_src;
          rf_sel_b_d = cmd_dst;
          ill_d      = !cmd_is_legal(cmd_op, cmd_size);
          illegal_d  = ill_d;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (ill_q) begin
          state_d = ST_IDLE;
        end else begin
          src_val_d = rf_data_a;
          dst_val_d = rf_data_b;
          res_d     = '0;
          cnt_d     = '0;
          carry_d   = 1'b0;
          z_d       = 1'b1;
          state_d   = ST_SLICE;
        end
      end
      ST_SLICE: begin
        res_d   = res_q | (DATA_W'(s_result) << (32'(cnt_q) * SLICE_W));
        carry_d = s_cout;
        z_d     = z_q & s_zero;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == k_last) begin
          state_d      = ST_WRITE;
          rf_we_d      = 1'b1;
          done_d       = 1'b1;
          rf_wsel_d    = dst_q;
          rf_wdata_d   = (dst_val_q & ~wmask) | (res_d & wmask);
          ccr_d[CCR_N] = s_msb;
          ccr_d[CCR_Z] = z_q & s_zero;
          ccr_d[CCR_V] = s_ovf;
          ccr_d[CCR_C] = s_cout;
          if (arith) begin
            ccr_d[CCR_X] = s_cout;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      size_q    <= '0;
      dst_q     <= '0;
      ill_q     <= 1'b0;
      src_val_q <= '0;
      dst_val_q <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      z_q       <= 1'b0;
      cmd_ready <= 1'b1;
      rf_sel_a  <= '0;
      rf_sel_b  <= '0;
      rf_we     <= 1'b0;
      rf_wsel   <= '0;
      rf_wdata  <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      ccr       <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      size_q    <= size_d;
      dst_q     <= dst_d;
      ill_q     <= ill_d;
      src_val_q <= src_val_d;
      dst_val_q <= dst_val_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      z_q       <= z_d;
      cmd_ready <= cmd_ready_d;
      rf_sel_a  <= rf_sel_a_d;
      rf_sel_b  <= rf_sel_b_d;
      rf_we     <= rf_we_d;
      rf_wsel   <= rf_wsel_d;
      rf_wdata  <= rf_wdata_d;
      done      <= done_d;
      illegal   <= illegal_d;
      ccr       <= ccr_d;
    end
  end

endmodule

// File: tb/tb_dreg_alu_sequencer.sv
// Directed bench: three sequencers (SLICE_W 8/16/32) run the same commands against private register files.
module tb_dreg_alu_sequencer;
  import dreg_alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_size;
  logic [2:0]  cmd_src;
  logic [2:0]  cmd_dst;

  logic        ready   [3];
  logic [2:0]  sel_a   [3];
  logic [2:0]  sel_b   [3];
  logic        we      [3];
  logic [2:0]  wsel    [3];
  logic [31:0] wdata   [3];
  logic        done    [3];
  logic        illegal [3];
  logic [4:0]  ccr     [3];

  logic [31:0] rf [3][8];
  logic        ld_en;
  logic [2:0]  ld_sel;
  logic [31:0] ld_data;
  logic [31:0] init_v [8];

  int vecs = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dreg_alu_sequencer #(
      .DATA_W  (32),
      .SLICE_W (8 << g),
      .SEL_W   (3)
    ) u_dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (ready[g]),
      .cmd_op    (cmd_op),
      .cmd_size  (cmd_size),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .rf_sel_a  (sel_a[g]),
      .rf_sel_b  (sel_b[g]),
      .rf_data_a (rf[g][sel_a[g]]),
      .rf_data_b (rf[g][sel_b[g]]),
      .rf_we     (we[g]),
      .rf_wsel   (wsel[g]),
      .rf_wdata  (wdata[g]),
      .done      (done[g]),
      .illegal   (illegal[g]),
      .ccr       (ccr[g])
    );
  end

  // Register file write port per instance, plus a bench preload path.
  always @(posedge CLK) begin
    for (int g = 0; g < 3; g++) begin
      if (we[g]) rf[g][wsel[g]] <= wdata[g];
      if (ld_en) rf[g][ld_sel] <= ld_data;
    end
  end

  task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s sw%0d: observed %h expected %h", tag, 8 << g, obs, exp);
    end
  endtask

  // Hand table of accept-to-done latency: [instance][size], instances are SLICE_W 8/16/32.
  function automatic int exp_lat(input int g, input logic [1:0] size);
    int t [3][3];
    t[0][0] = 3; t[0][1] = 4; t[0][2] = 6;
    t[1][0] = 3; t[1][1] = 3; t[1][2] = 4;
    t[2][0] = 3; t[2][1] = 3; t[2][2] = 3;
    return t[g][size];
  endfunction

  // Issue one command in the current cycle and observe eight following cycles.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [1:0] size,
                         input logic [2:0] src, input logic [2:0] dst,
                         input logic [31:0] exp_val, input logic [4:0] exp_ccr, input logic exp_ill);
    int done_n [3];
    int ill_n  [3];
    int done_c [3];
    int we_c   [3];
    for (int g = 0; g < 3; g++) begin
      done_n[g] = 0; ill_n[g] = 0; done_c[g] = 0; we_c[g] = 0;
      check({tag, ".ready_T"}, g, 32'(ready[g]), 32'd1);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_size = size; cmd_src = src; cmd_dst = dst;
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK);
      if (n == 1) cmd_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (done[g]) begin done_c[g]++; done_n[g] = n; end
        if (we[g]) we_c[g]++;
        if (illegal[g]) ill_n[g] = n;
        if (n == 1) check({tag, ".busy_T1"}, g, 32'(ready[g]), 32'd0);
        if (exp_ill && n == 2) check({tag, ".ready_T2"}, g, 32'(ready[g]), 32'd1);
      end
    end
    for (int g = 0; g < 3; g++) begin
      check({tag, ".we_count"}, g, 32'(we_c[g]), exp_ill ? 32'd0 : 32'd1);
      check({tag, ".done_count"}, g, 32'(done_c[g]), exp_ill ? 32'd0 : 32'd1);
      check({tag, ".illegal_at"}, g, 32'(ill_n[g]), exp_ill ? 32'd1 : 32'd0);
      if (!exp_ill) check({tag, ".done_at"}, g, 32'(done_n[g]), 32'(exp_lat(g, size)));
      check({tag, ".reg"}, g, rf[g][dst], exp_val);
      check({tag, ".ccr"}, g, 32'(ccr[g]), 32'(exp_ccr));
    end
  endtask

  initial begin
    int we_c [3];
    int done_c [3];
    RESET = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_size = '0; cmd_src = '0; cmd_dst = '0;
    ld_en = 1'b0; ld_sel = '0; ld_data = '0;
    init_v[0] = 32'h0000FFFF; init_v[1] = 32'h00000001;
    init_v[2] = 32'h12340000; init_v[3] = 32'h00000001;
    init_v[4] = 32'hAAAAAA7F; init_v[5] = 32'h00000001;
    init_v[6] = 32'hDEADBEEF; init_v[7] = 32'h80008001;

    repeat (2) @(negedge CLK);
    // {ready, we, done, illegal, ccr, sel_a, sel_b, wsel} after reset
    for (int g = 0; g < 3; g++) begin
      check("reset.ctrl", g, 32'({ready[g], we[g], done[g], illegal[g], ccr[g], sel_a[g], sel_b[g], wsel[g]}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 3'd0, 3'd0}));
      check("reset.wdata", g, wdata[g], 32'h0);
    end
    RESET = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ld_en = 1'b1; ld_sel = 3'(i); ld_data = init_v[i];
      @(negedge CLK);
    end
    ld_en = 1'b0;
    @(negedge CLK);

    run_cmd("add_long",  OP_ADD,  SZ_LONG, 3'd1, 3'd0, 32'h00010000, 5'b00000, 1'b0);
    run_cmd("add_byte",  OP_ADD,  SZ_BYTE, 3'd5, 3'd4, 32'hAAAAAA80, 5'b01010, 1'b0);
    run_cmd("sub_word",  OP_SUB,  SZ_WORD, 3'd3, 3'd2, 32'h1234FFFF, 5'b11001, 1'b0);
    run_cmd("eor_self",  OP_EOR,  SZ_LONG, 3'd6, 3'd6, 32'h00000000, 5'b10100, 1'b0);
    run_cmd("ill_size",  OP_ADD,  2'b11,   3'd0, 3'd1, 32'h00000001, 5'b10100, 1'b1);
    run_cmd("ill_op",    3'b111,  SZ_BYTE, 3'd0, 3'd1, 32'h00000001, 5'b10100, 1'b1);

    // Reset while every instance is in SLICE of a long ADD D1 -> D0.
    for (int g = 0; g < 3; g++) begin we_c[g] = 0; done_c[g] = 0; end
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_size = SZ_LONG; cmd_src = 3'd1; cmd_dst = 3'd0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK);
      for (int g = 0; g < 3; g++) begin
        if (we[g]) we_c[g]++;
        if (done[g]) done_c[g]++;
        if (n == 4) check("rst_mid.ready", g, 32'(ready[g]), 32'd1);
      end
      if (n == 1) cmd_valid = 1'b0;
      if (n == 2) RESET = 1'b1;
      if (n == 3) RESET = 1'b0;
    end
    for (int g = 0; g < 3; g++) begin
      check("rst_mid.we_count", g, 32'(we_c[g]), 32'd0);
      check("rst_mid.done_count", g, 32'(done_c[g]), 32'd0);
      check("rst_mid.ccr", g, 32'(ccr[g]), 32'd0);
      check("rst_mid.reg", g, rf[g][0], 32'h00010000);
    end

    run_cmd("move_word", OP_MOVE, SZ_WORD, 3'd7, 3'd0, 32'h00018001, 5'b01000, 1'b0);
    run_cmd("and_word",  OP_AND,  SZ_WORD, 3'd4, 3'd2, 32'h1234AA80, 5'b01000, 1'b0);
    run_cmd("or_byte",   OP_OR,   SZ_BYTE, 3'd3, 3'd6, 32'h00000001, 5'b00000, 1'b0);
    run_cmd("sub_zero",  OP_SUB,  SZ_LONG, 3'd5, 3'd3, 32'h00000000, 5'b00100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
